// File: rtl/axi_wr_arbiter.sv
// Shares one AXI3 write port (AW/W/B) between NumReq burst requesters, one burst at a time.
// Define AXI_WR_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module axi_wr_arbiter #(
    parameter int NumReq      = 2,
    parameter int DataBits    = 64,
    parameter int AxiAddrBits = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NumReq-1:0]                 req_awvalid,
    output logic [NumReq-1:0]                 req_awready,
    input  logic [NumReq*AxiAddrBits-1:0]     req_awaddr,
    input  logic [NumReq*4-1:0]               req_awlen,
    input  logic [NumReq-1:0]                 req_wvalid,
    output logic [NumReq-1:0]                 req_wready,
    input  logic [NumReq*DataBits-1:0]        req_wdata,
    input  logic [NumReq*DataBits/8-1:0]      req_wstrb,
    input  logic [NumReq-1:0]                 req_wlast,
    output logic [NumReq-1:0]                 req_bvalid,
    input  logic [NumReq-1:0]                 req_bready,
    output logic [1:0]                        req_bresp,
    output logic                              m_awvalid,
    input  logic                              m_awready,
    output logic [AxiAddrBits-1:0]            m_awaddr,
    output logic [3:0]                        m_awlen,
    output logic [3:0]                        m_awid,
    output logic [2:0]                        m_awsize,
    output logic [1:0]                        m_awburst,
    output logic                              m_wvalid,
    input  logic                              m_wready,
    output logic [DataBits-1:0]               m_wdata,
    output logic [DataBits/8-1:0]             m_wstrb,
    output logic                              m_wlast,
    output logic [3:0]                        m_wid,
    input  logic                              m_bvalid,
    output logic                              m_bready,
    input  logic [1:0]                        m_bresp,
    output logic [NumReq-1:0]                 grant,
    output logic                              wlast_err
);
    localparam int IdxW     = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int StrbBits = DataBits / 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                   state;
    logic [IdxW-1:0]          gidx;
    logic [IdxW-1:0]          win;
    logic                     win_vld;
    logic [NumReq-1:0]        win_oh;
    logic [AxiAddrBits-1:0]   addr_q;
    logic [3:0]               len_q;
    logic [4:0]               cnt;
    logic                     last_beat;
    logic                     w_hs;
    logic                     b_hs;

`ifdef AXI_WR_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest asserted index is written last and wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req_awvalid[k]) begin
                win     = IdxW'(k);
                win_vld = 1'b1;
            end
        end
    end
`else
    logic [IdxW-1:0] ptr;
    int              idx;

    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = 0;
        for (int k = 0; k < NumReq; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NumReq) idx = idx - NumReq;
            if (!win_vld && req_awvalid[IdxW'(idx)]) begin
                win     = IdxW'(idx);
                win_vld = 1'b1;
            end
        end
    end
`endif

    assign win_oh    = NumReq'(1) << win;
    assign last_beat = (cnt == {1'b0, len_q});
    assign w_hs      = (state == DATA) && req_wvalid[gidx] && m_wready;
    assign b_hs      = (state == RESP) && m_bvalid && req_bready[gidx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gidx      <= '0;
            grant     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
            wlast_err <= 1'b0;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
            ptr       <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (win_vld) begin
                    gidx   <= win;
                    grant  <= win_oh;
                    addr_q <= req_awaddr[int'(win)*AxiAddrBits +: AxiAddrBits];
                    len_q  <= req_awlen[int'(win)*4 +: 4];
                    state  <= ADDR;
                end
                ADDR: if (m_awready) begin
                    cnt   <= '0;
                    state <= DATA;
                end
                DATA: if (w_hs) begin
                    cnt <= cnt + 5'd1;
                    if (req_wlast[gidx] != last_beat) wlast_err <= 1'b1;
                    if (last_beat) state <= RESP;
                end
                RESP: if (b_hs) begin
                    grant <= '0;
                    state <= IDLE;
`ifndef AXI_WR_ARB_FIXED_PRIO_EN
                    ptr   <= (gidx == IdxW'(NumReq - 1)) ? '0 : gidx + 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // rst_n gates the only path that is not decoded from registered state.
    assign req_awready = (rst_n && state == IDLE && win_vld) ? win_oh : '0;

    assign m_awvalid = (state == ADDR);
    assign m_awaddr  = addr_q;
    assign m_awlen   = len_q;
    assign m_awid    = 4'(gidx);
    assign m_awsize  = 3'($clog2(StrbBits));
    assign m_awburst = 2'b01;

    assign m_wvalid   = (state == DATA) && req_wvalid[gidx];
    assign req_wready = (state == DATA && m_wready) ? grant : '0;
    assign m_wdata    = (state == DATA) ? req_wdata[int'(gidx)*DataBits +: DataBits] : '0;
    assign m_wstrb    = (state == DATA) ? req_wstrb[int'(gidx)*StrbBits +: StrbBits] : '0;
    assign m_wlast    = (state == DATA) && last_beat;
    assign m_wid      = 4'(gidx);

    assign m_bready   = (state == RESP) && req_bready[gidx];
    assign req_bvalid = (state == RESP && m_bvalid) ? grant : '0;
    assign req_bresp  = (state == RESP) ? m_bresp : 2'b00;
endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Table-driven burst bench for axi_wr_arbiter with AW/W scoreboard queues.
module tb_axi_wr_arbiter;
    localparam int NR = 2;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_awvalid, req_awready;
    logic [NR*AW-1:0]  req_awaddr;
    logic [NR*4-1:0]   req_awlen;
    logic [NR-1:0]     req_wvalid, req_wready;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR*SW-1:0]  req_wstrb;
    logic [NR-1:0]     req_wlast, req_bvalid, req_bready;
    logic [1:0]        req_bresp;
    logic              m_awvalid, m_awready;
    logic [AW-1:0]     m_awaddr;
    logic [3:0]        m_awlen, m_awid;
    logic [2:0]        m_awsize;
    logic [1:0]        m_awburst;
    logic              m_wvalid, m_wready, m_wlast;
    logic [DW-1:0]     m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic [3:0]        m_wid;
    logic              m_bvalid, m_bready;
    logic [1:0]        m_bresp;
    logic [NR-1:0]     grant;
    logic              wlast_err;

    axi_wr_arbiter #(.NumReq(NR), .DataBits(DW), .AxiAddrBits(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_awvalid(req_awvalid), .req_awready(req_awready), .req_awaddr(req_awaddr), .req_awlen(req_awlen),
        .req_wvalid(req_wvalid), .req_wready(req_wready), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_wlast(req_wlast), .req_bvalid(req_bvalid), .req_bready(req_bready), .req_bresp(req_bresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awid(m_awid), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_wid(m_wid), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .grant(grant), .wlast_err(wlast_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         r;
        logic [31:0] addr;
        logic [3:0] len;
        int         stall;      // percent of data cycles with m_wready low
        int         bdly;       // cycles before m_bvalid
        logic [1:0] bresp;
        int         bad;        // beat index with a spurious wlast, -1 none
        int         abort;      // beat index at which the burst is abandoned, -1 none
        int         exp_cycles; // request-to-IDLE cycles, -1 not checked
        logic       exp_err;
    } burst_t;

    int n_chk  = 0;
    int n_fail = 0;
    logic [39:0] aw_q[$];
    logic [72:0] w_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_burst(input burst_t b, output int cycles, output bit aborted);
        logic [NR-1:0] oh;
        logic [72:0]   ew;
        logic [39:0]   ea;
        int beat, budget;
        bit pushed;
        oh = NR'(1) << b.r;
        cycles = 0;
        aborted = 0;
        @(negedge clk);
        req_awvalid[b.r] = 1'b1;
        req_awaddr[b.r*AW +: AW] = b.addr;
        req_awlen[b.r*4 +: 4] = b.len;
        aw_q.push_back({b.addr, b.len, 4'(b.r)});
        #1 chk("awready", req_awready, oh);
        cycles++;
        @(negedge clk);
        req_awvalid[b.r] = 1'b0;
        m_awready = 1'b1;
        #1 chk("grant_addr", grant, oh);
        chk("m_awvalid", m_awvalid, 1);
        if (m_awvalid && aw_q.size() > 0) begin
            ea = aw_q.pop_front();
            chk("aw_fields", {m_awaddr, m_awlen, m_awid}, ea);
        end
        cycles++;
        beat = 0; pushed = 0; budget = 0;
        while (beat <= int'(b.len) && budget < 400) begin
            @(negedge clk);
            m_awready = 1'b0;
            budget++; cycles++;
            if (b.abort == beat) begin
                aborted = 1;
                return;
            end
            if (!pushed) begin
                req_wdata[b.r*DW +: DW] = {$urandom, $urandom};
                req_wstrb[b.r*SW +: SW] = SW'($urandom);
                req_wlast[b.r] = (beat == int'(b.len)) || (beat == b.bad);
                req_wvalid[b.r] = 1'b1;
                w_q.push_back({req_wdata[b.r*DW +: DW], req_wstrb[b.r*SW +: SW], beat == int'(b.len)});
                pushed = 1;
            end
            m_wready = ($urandom_range(99) >= b.stall);
            #1 chk("grant_data", grant, oh);
            if (m_wvalid && m_wready) begin
                ew = w_q.pop_front();
                chk($sformatf("wbeat%0d", beat), {m_wdata, m_wstrb, m_wlast}, ew);
                chk("req_wready", req_wready, oh);
                beat++; pushed = 0;
            end
        end
        if (budget >= 400) chk("w_timeout", 0, 1);
        @(negedge clk);
        req_wvalid[b.r] = 1'b0; req_wlast[b.r] = 1'b0; m_wready = 1'b0;
        req_bready[b.r] = 1'b1;
        cycles++;
        for (int d = 0; d < b.bdly; d++) begin
            #1 chk("bvalid_wait", req_bvalid, 0);
            chk("grant_resp", grant, oh);
            @(negedge clk);
            cycles++;
        end
        m_bvalid = 1'b1; m_bresp = b.bresp;
        #1 chk("req_bvalid", req_bvalid, oh);
        chk("req_bresp", req_bresp, b.bresp);
        chk("m_bready", m_bready, 1);
        @(negedge clk);
        m_bvalid = 1'b0; m_bresp = 2'b00; req_bready[b.r] = 1'b0;
        #1 chk("grant_idle", grant, 0);
        chk("wlast_err", wlast_err, b.exp_err);
        if (b.exp_cycles >= 0) chk("burst_cycles", cycles, b.exp_cycles);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        burst_t vec[5];
        burst_t rb;
        logic [NR-1:0] exp_alt[4];
        int cyc, ng;
        bit ab;

        vec[0] = '{0, 32'h100,  4'd3,  0,  0, 2'b00, -1, -1, 7, 1'b0};
        vec[1] = '{1, 32'h2000, 4'd15, 50, 5, 2'b00, -1, -1, -1, 1'b0};
        vec[2] = '{0, 32'h40,   4'd0,  0,  0, 2'b10, -1, -1, 4, 1'b0};
        vec[3] = '{1, 32'h300,  4'd3,  0,  0, 2'b00,  1, -1, 7, 1'b1};
        vec[4] = '{0, 32'h500,  4'd7,  30, 2, 2'b01, -1, -1, -1, 1'b1};
`ifdef AXI_WR_ARB_FIXED_PRIO_EN
        exp_alt = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_alt = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

        rst_n = 1'b0;
        req_awvalid = '0; req_awaddr = '0; req_awlen = '0;
        req_wvalid = '0; req_wdata = '0; req_wstrb = '0; req_wlast = '0; req_bready = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        repeat (3) @(negedge clk);
        #1 chk("rst_grant", grant, 0);
        chk("rst_wlast_err", wlast_err, 0);
        chk("rst_aw", {m_awvalid, m_awaddr, m_awlen}, 0);
        chk("rst_const", {m_awsize, m_awburst}, {3'd3, 2'b01});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_burst(vec[i], cyc, ab);

        // Abandon a len-7 burst after two beats by pulling reset.
        rb = '{0, 32'h700, 4'd7, 0, 0, 2'b00, -1, 2, -1, 1'b0};
        run_burst(rb, cyc, ab);
        chk("aborted", ab, 1);
        rst_n = 1'b0;
        req_awvalid[1] = 1'b1;
        #1 chk("rst_mid_ready", {req_awready, req_wready, req_bvalid}, 0);
        chk("rst_mid_m", {m_awvalid, m_wvalid, m_wlast, m_bready, m_awaddr, m_awlen}, 0);
        chk("rst_mid_state", {grant, wlast_err}, 0);
        @(negedge clk);
        req_awvalid = '0; req_wvalid = '0; req_wlast = '0;
        m_wready = 1'b0;
        aw_q.delete(); w_q.delete();
        rst_n = 1'b1;
        rb = '{1, 32'h800, 4'd1, 0, 0, 2'b00, -1, -1, 5, 1'b0};
        run_burst(rb, cyc, ab);

        // Both requesters hold len-0 requests; slave B is valid early to show it is held off in DATA.
        @(negedge clk);
        req_awlen = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b00;
        req_bready = '1; req_wvalid = '1; req_wlast = '1; req_awvalid = '1;
        ng = 0;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            #1;
            if (req_awready != '0) begin
                chk($sformatf("alt_grant%0d", ng), req_awready, exp_alt[ng]);
                ng++;
            end
            if (m_wvalid) chk("bready_in_data", m_bready, 0);
            @(negedge clk);
        end
        if (ng < 4) chk("alt_timeout", ng, 4);
        req_awvalid = '0; req_wvalid = '0; req_bready = '0; req_wlast = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_wr_arbiter.md
# axi_wr_arbiter

Shares one AXI3 write port (AW/W/B) between `NumReq` independent burst requesters, in front of a single AXI slave such as the memory model or a DDR controller port. Grants one requester at a time, forwards its address phase, streams exactly `awlen+1` data beats, then routes the write response back before re-arbitrating. Only one burst is outstanding at a time; read channels are out of scope.

## Interface
- `NumReq`, 2: number of requesters, 2..8.
- `DataBits`, 64: write data width.
- `AxiAddrBits`, 32: byte address width.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_awvalid`  in  NumReq  per-requester burst request.
- `req_awready`  out  NumReq  address accepted (one-hot or zero).
- `req_awaddr`  in  NumReq*AxiAddrBits  packed byte addresses; requester i occupies slice i.
- `req_awlen`  in  NumReq*4  packed burst lengths (0=1 beat .. 15=16 beats).
- `req_wvalid` / `req_wready`  in / out  NumReq  data handshakes.
- `req_wdata`  in  NumReq*DataBits  packed write data.
- `req_wstrb`  in  NumReq*DataBits/8  packed byte strobes.
- `req_wlast`  in  NumReq  last-beat marker; checked only.
- `req_bvalid` / `req_bready`  out / in  NumReq  response handshakes.
- `req_bresp`  out  2  response code; shared, valid with `req_bvalid`.
- `m_awvalid`, `m_awready`, `m_awaddr`, `m_awlen`, `m_awid[3:0]`, `m_awsize[2:0]`, `m_awburst[1:0]`: master AW; `m_awid` = granted index, `m_awsize` = log2(DataBits/8), `m_awburst` = 2'b01.
- `m_wvalid`, `m_wready`, `m_wdata`, `m_wstrb`, `m_wlast`, `m_wid[3:0]`: master W; `m_wid` = granted index.
- `m_bvalid`, `m_bready`, `m_bresp[1:0]`: master B; `m_bid` not used.
- `grant`  out  NumReq  one-hot owner of current burst; zero in IDLE.
- `wlast_err`  out  1  sticky: a requester's `wlast` disagreed with the beat count.

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE: if any `req_awvalid`, select winner g; assert `req_awready[g]` combinationally that cycle; register addr, len, `grant` = 1<<g; go to ADDR. Otherwise stay.
- ADDR: `m_awvalid`=1 with registered addr/len; on `m_awready` go to DATA, beat counter = 0.
- DATA: `m_wvalid`=`req_wvalid[g]`, `req_wready[g]`=`m_wready`, data/strb muxed from slice g, `m_wlast` = (count == len). Each handshake increments count (5-bit). On handshake with count == len go to RESP. If `req_wlast[g]` != (count == len) on any handshake, set `wlast_err`.
- RESP: `m_bready`=`req_bready[g]`, `req_bvalid[g]`=`m_bvalid`, `req_bresp`=`m_bresp`. On handshake: go to IDLE, clear `grant`, round-robin pointer = g+1 mod NumReq.
- Non-granted requesters see all ready/valid outputs low.
- Round-robin: search starts at pointer, first asserted `req_awvalid` wins.

## Timing
- Reset (async assert, sync release): state IDLE, pointer 0, `grant`=0, `wlast_err`=0, all valid/ready outputs 0, `m_awaddr`/`m_awlen`=0.
- Reset mid-burst abandons the burst immediately; no W/B completion issued.
- `m_awvalid` rises 1 cycle after `req_awready` pulse; held until `m_awready`.
- W path combinational (zero added latency). Minimum burst occupancy with no stalls: len+4 cycles (IDLE, ADDR, len+1 DATA, RESP); next grant can be taken in the IDLE cycle immediately after.
- `m_bvalid` arriving while in DATA is not accepted until RESP (`m_bready`=0 outside RESP).
- Request withdrawn before grant: no effect; AXI forbids withdrawal, not checked.

## Configuration
- `AXI_WR_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest asserted index always wins; pointer logic removed.
- Undefined (default): round-robin as above.

## Test plan
- Single requester 0, addr 0x100, len 3, no stalls -> `m_awaddr`=0x100, `m_awlen`=3, 4 beats with `m_wlast` on beat 4 only, `req_bvalid[0]` in RESP, total 7 cycles from request to IDLE.
- Requesters 0 and 1 both request continuously, len 0 -> grants alternate 0,1,0,1; with `AXI_WR_ARB_FIXED_PRIO_EN` -> grants all 0.
- Slave `m_wready` 50% random, `m_bvalid` delayed 5 cycles, len 15 -> 16 beats in order, data bit-exact, no grant change until B handshake.
- Requester 1 asserts `wlast` on beat 2 of len 3 -> `wlast_err`=1 and stays set; burst still completes with 4 beats.
- Assert `rst_n`=0 mid-DATA (beat 2 of 8) -> all outputs 0 same cycle; after release a new len-1 burst from requester 1 completes normally.
- `m_bresp`=2'b10 on completion -> `req_bresp`=2'b10 with `req_bvalid[g]`.
